// File: rtl/cache_pkg.sv
// Shared line-fill definitions: word/line geometry, fill FSM states, byte merge helper.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package cache_pkg;

  localparam int WORD_W      = 32;
  localparam int WORDS       = 4;
  localparam int OFFSET_BITS = 2;
  localparam int BE_W        = WORD_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  // Byte-wise select: a set enable takes the byte from data, otherwise it keeps the byte from word.
  function automatic logic [WORD_W-1:0] byte_merge(
    input logic [WORD_W-1:0] word,
    input logic [WORD_W-1:0] data,
    input logic [BE_W-1:0]   be
  );
    logic [WORD_W-1:0] res;
    res = word;
    for (int j = 0; j < BE_W; j++) begin
      if (be[j]) res[8*j +: 8] = data[8*j +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/line_word_writer.sv
// Steers one incoming word into its 2-bit slot of a 4-word line register, optionally byte-merged.
// Latency: merged word visible combinationally on o_wdata; the line register updates on the next edge.
// Backpressure: none; writes happen whenever i_we is high.
module line_word_writer
  import cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_we,
  input  logic [OFFSET_BITS-1:0] i_slot,
  input  logic [WORD_W-1:0]      i_data,
  input  logic                   i_merge,
  input  logic [WORD_W-1:0]      i_st_data,
  input  logic [BE_W-1:0]        i_st_be,
  output logic [WORD_W-1:0]      o_wdata,
  output logic [WORDS*WORD_W-1:0] o_line
);

  logic [WORD_W-1:0] r_words [WORDS];

  // Word actually written: the memory beat, with the pending store overlaid when requested.
  always_comb begin
    o_wdata = i_merge ? byte_merge(i_data, i_st_data, i_st_be) : i_data;
  end

  // Slot decode and write into the line register (inverse of the read-side 4:1 select).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) r_words[i] <= '0;
    end else if (i_we) begin
      r_words[i_slot] <= o_wdata;
    end
  end

  // Flatten the array so word i sits at bits [32i+31:32i].
  always_comb begin
    o_line = '0;
    for (int i = 0; i < WORDS; i++) o_line[i*WORD_W +: WORD_W] = r_words[i];
  end

endmodule

// File: rtl/line_fill_buffer.sv
// Assembles a cache line from critical-word-first memory beats, forwarding the (store-merged) critical word early.
// Latency: zero-wait memory gives mem_req 1 cycle, crit_valid 3 cycles and line_valid 6 cycles after fill_start.
// Backpressure: mem_req held until mem_gnt; mem_rvalid low stalls beat capture; fill_start ignored while busy.
module line_fill_buffer
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fill_start,
  input  logic [ADDR_W-1:0]       fill_addr,
  input  logic                    st_en,
  input  logic [WORD_W-1:0]       st_data,
  input  logic [BE_W-1:0]         st_be,
  output logic                    busy,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [WORD_W-1:0]       mem_rdata,
  output logic                    crit_valid,
  output logic [WORD_W-1:0]       crit_data,
  output logic                    line_valid,
  output logic [ADDR_W-1:0]       line_addr,
  output logic [WORDS*WORD_W-1:0] line_data
);

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:2]      r_addr;
  logic [ADDR_W-1:0]      r_line_addr;
  logic                   r_st_en;
  logic [WORD_W-1:0]      r_st_data;
  logic [BE_W-1:0]        r_st_be;
  logic [OFFSET_BITS-1:0] r_cnt;
  logic                   r_crit_valid;
  logic [WORD_W-1:0]      r_crit_data;

  logic                   w_start;
  logic                   w_beat;
  logic                   w_first;
  logic                   w_last;
  logic [OFFSET_BITS-1:0] w_slot;
  logic [WORD_W-1:0]      w_wdata;
  logic                   w_unused_addr_lsb;

  // Byte offset within the word never matters: requests and slots are word-granular.
  assign w_unused_addr_lsb = ^fill_addr[1:0];

  assign w_start = (r_state == IDLE) & fill_start;
  assign w_beat  = (r_state == DATA) & mem_rvalid;
  assign w_first = w_beat & (r_cnt == '0);
  assign w_last  = w_beat & (r_cnt == OFFSET_BITS'(WORDS - 1));
  // Wrapping slot: critical offset plus beat index, modulo 4 by width.
  assign w_slot  = r_addr[3:2] + r_cnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: request, collect four beats, announce the line, return to idle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (fill_start) w_next = REQ;
      REQ:     if (mem_gnt)    w_next = DATA;
      DATA:    if (w_last)     w_next = DONE;
      DONE:                    w_next = IDLE;
      default:                 w_next = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy       = (r_state != IDLE);
    mem_req    = (r_state == REQ);
    line_valid = (r_state == DONE);
  end

  // Capture the miss address and pending store when a fill is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_st_en   <= 1'b0;
      r_st_data <= '0;
      r_st_be   <= '0;
    end else if (w_start) begin
      r_addr    <= fill_addr[ADDR_W-1:2];
      r_st_en   <= st_en;
      r_st_data <= st_data;
      r_st_be   <= st_be;
    end
  end

  // Beat counter: restarts per fill and naturally wraps to 0 after the fourth beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_cnt <= '0;
    else if (w_start) r_cnt <= '0;
    else if (w_beat)  r_cnt <= r_cnt + 1'b1;
  end

  // Critical word forward and line address; both change only on a fill's first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crit_valid <= 1'b0;
      r_crit_data  <= '0;
      r_line_addr  <= '0;
    end else begin
      r_crit_valid <= w_first;
      if (w_first) begin
        r_crit_data <= w_wdata;
        r_line_addr <= {r_addr[ADDR_W-1:4], 4'b0000};
      end
    end
  end

  line_word_writer u_writer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_beat),
    .i_slot    (w_slot),
    .i_data    (mem_rdata),
    .i_merge   (w_first & r_st_en),
    .i_st_data (r_st_data),
    .i_st_be   (r_st_be),
    .o_wdata   (w_wdata),
    .o_line    (line_data)
  );

  assign mem_addr   = {r_addr, 2'b00};
  assign line_addr  = r_line_addr;
  assign crit_valid = r_crit_valid;
  assign crit_data  = r_crit_data;

endmodule
